moving_avg: RTL
===============

Name: moving_avg

Overview:
- Streaming boxcar (moving-average) filter over a window of LEN samples.
- Sits directly downstream of the block-RAM delay line. It takes the current sample plus the same sample delayed by LEN accepted samples, and keeps a running sum: sum += di - di_dly.
- Outputs the running sum and the rounded window mean. Typical use: post-FFT or ADC smoothing in the same datapath.

Parameters:
- DATA_WIDTH, 25, sample width; signed two's complement.
- LEN, 512, window length; must be a power of two and >= 2.
- LEN_LOG2, $clog2(LEN), derived; not overridden.
- SUM_WIDTH, DATA_WIDTH+LEN_LOG2, derived accumulator width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous clear of window state; same effect as rst, for use without a global reset.
- in_valid  in  1  di/di_dly hold an accepted sample this cycle.
- di  in  DATA_WIDTH  current sample, signed.
- di_dly  in  DATA_WIDTH  sample accepted LEN in_valid-cycles earlier. The delay source advances only on in_valid.
- out_valid  out  1  avg_o/sum_o hold a full-window result (1-cycle pulse per result).
- sum_o  out  SUM_WIDTH  window sum, signed.
- avg_o  out  DATA_WIDTH  rounded mean, signed.
- full  out  1  window full (state RUN).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset/clr values: accumulator 0; fill count 0; state FILL; all pipeline valids 0; out_valid 0; sum_o 0; avg_o 0; full 0.
- clr vs rst: identical. clr with in_valid in the same cycle means clr wins and the sample is dropped. Reset mid-stream discards all in-flight results; no out_valid in the cycles after.
- State machine, two states:
  - FILL: di_dly is masked to 0, because the delay line holds no valid data yet. fill_cnt increments per accepted sample. The accept with fill_cnt == LEN-1 moves to RUN.
  - RUN: di_dly is used unmasked. Leaves RUN only on rst/clr.
- Pipeline, 3 stages; in_valid at cycle N gives out_valid at cycle N+3.
  - S1: diff = sext(di) - sext(masked di_dly), DATA_WIDTH+1 bits, registered along with a valid bit and a win_full tag. win_full is set when the sample completes or follows a full window, i.e. state RUN or the final FILL accept.
  - S2: acc <= acc + sext(diff) when S1 valid; holds otherwise. SUM_WIDTH bits. Cannot overflow, since |sum| <= LEN*2^(DATA_WIDTH-1).
  - S3: sum_o <= acc; avg_o <= (acc + 2^(LEN_LOG2-1)) >>> LEN_LOG2, truncated to DATA_WIDTH. This is round half toward +inf; the result always fits DATA_WIDTH. out_valid <= S2 valid AND win_full.
- Outputs hold their last value when out_valid = 0.
- Gaps: in_valid low leaves acc and fill_cnt unchanged. Back-to-back in_valid every cycle is supported at full throughput, with no backpressure.
- First out_valid: 3 cycles after the LEN-th accepted sample following reset/clr. After that, exactly one out_valid per accepted sample.
- full asserts the cycle after the LEN-th accept; independent of pipeline latency.
- Wrap-around: fill_cnt saturates in RUN and does not roll over. acc never wraps.

Test Plan (bench params DATA_WIDTH=8, LEN=4):
- Reset, then in_valid=1 every cycle, di=10. Required:
  - no out_valid for the first 3 samples.
  - first out_valid 3 cycles after the 4th sample, with sum_o=40, avg_o=10.
  - full=1 from the cycle after the 4th accept.
- Ramp di=0,1,2,3,4,5 with correct di_dly. Required:
  - sums 6, 10, 14.
  - avg_o 2, 3, 4 (6+2>>2=2; 10+2>>2=3).
- Constant -3. Required: sum_o=-12, avg_o=-3 (floor(-2.5)). Constant -2 with pattern sum -6: avg_o=-1.
- Extremes. Required:
  - all 127 gives sum_o=508, avg_o=127.
  - all -128 gives sum_o=-512, avg_o=-128.
  - no overflow on either.
- in_valid alternating 1/0 in RUN. Required: acc changes only on valid cycles; out_valid pulses exactly 3 cycles after each accept.
- clr asserted with in_valid=1 mid-RUN. Required:
  - sample dropped.
  - in-flight out_valids suppressed.
  - full=0.
  - next out_valid only 3 cycles after 4 new accepts, with di_dly masked during FILL.
  - repeat the same sequence using rst.

Source files
------------

// File: rtl/moving_avg.sv
// Streaming boxcar filter over LEN samples. The running window sum is kept as
// acc += di - di_dly, where di_dly comes from an external delay line of depth
// LEN. A 3-stage pipeline produces the window sum and its rounded mean.
module moving_avg #(
  parameter int DATA_WIDTH = 25,
  parameter int LEN        = 512,
  parameter int LEN_LOG2   = $clog2(LEN),
  parameter int SUM_WIDTH  = DATA_WIDTH + LEN_LOG2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] di,
  input  logic signed [DATA_WIDTH-1:0] di_dly,
  output logic                         out_valid,
  output logic signed [SUM_WIDTH-1:0]  sum_o,
  output logic signed [DATA_WIDTH-1:0] avg_o,
  output logic                         full
);

  typedef enum logic {FILL, RUN} state_e;

  // Mean of the window: add half an LSB of the result, then arithmetic shift.
  // Rounds half toward +inf. The extra bit keeps the rounding add exact.
  function automatic logic signed [DATA_WIDTH-1:0] round_avg(
    input logic signed [SUM_WIDTH-1:0] s
  );
    logic signed [SUM_WIDTH:0] t;
    t = (SUM_WIDTH+1)'(s) + (SUM_WIDTH+1)'(LEN / 2);
    t = t >>> LEN_LOG2;
    return DATA_WIDTH'(t);
  endfunction

  state_e                      state_q;
  logic [LEN_LOG2-1:0]         fill_cnt_q;

  logic                        kill;
  logic                        accept;
  logic                        last_fill;
  logic signed [DATA_WIDTH:0]  diff_d;
  logic                        wf_d;

  logic signed [DATA_WIDTH:0]  diff_p1_q;
  logic                        vld_p1_q;
  logic                        wf_p1_q;

  logic signed [SUM_WIDTH-1:0] acc_d;
  logic signed [SUM_WIDTH-1:0] acc_p2_q;
  logic                        vld_p2_q;
  logic                        wf_p2_q;

  logic signed [SUM_WIDTH-1:0]  sum_p3_q;
  logic signed [DATA_WIDTH-1:0] avg_p3_q;
  logic                         vld_p3_q;

  // Input qualification, delayed-sample masking and the S1 difference.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] dly_m;
    logic signed [DATA_WIDTH:0]   di_x;
    logic signed [DATA_WIDTH:0]   dly_x;
    kill      = rst | clr;
    accept    = in_valid & ~kill;
    last_fill = (state_q == FILL) && (fill_cnt_q == LEN_LOG2'(LEN - 1));
    // The delay line carries no valid data until the window has filled once.
    dly_m     = (state_q == RUN) ? di_dly : '0;
    di_x      = (DATA_WIDTH+1)'(di);
    dly_x     = (DATA_WIDTH+1)'(dly_m);
    diff_d    = di_x - dly_x;
    wf_d      = (state_q == RUN) || last_fill;
    acc_d     = acc_p2_q + SUM_WIDTH'(diff_p1_q);
  end

  // Window fill tracking: FILL counts accepts, RUN is held until rst/clr.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
    end else if (accept && (state_q == FILL)) begin
      if (last_fill) begin
        state_q <= RUN;
      end else begin
        fill_cnt_q <= fill_cnt_q + LEN_LOG2'(1);
      end
    end
  end

  // ---- S1: difference of new and retiring sample ----
  always_ff @(posedge clk) begin
    if (kill) begin
      vld_p1_q  <= 1'b0;
      wf_p1_q   <= 1'b0;
      diff_p1_q <= '0;
    end else begin
      vld_p1_q <= accept;
      wf_p1_q  <= wf_d;
      if (accept) begin
        diff_p1_q <= diff_d;
      end
    end
  end

  // ---- S2: running window sum; bounded by LEN*2^(DATA_WIDTH-1), never wraps ----
  always_ff @(posedge clk) begin
    if (kill) begin
      vld_p2_q <= 1'b0;
      wf_p2_q  <= 1'b0;
      acc_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      wf_p2_q  <= wf_p1_q;
      if (vld_p1_q) begin
        acc_p2_q <= acc_d;
      end
    end
  end

  // ---- S3: publish sum and rounded mean for full windows only ----
  always_ff @(posedge clk) begin
    if (kill) begin
      vld_p3_q <= 1'b0;
      sum_p3_q <= '0;
      avg_p3_q <= '0;
    end else begin
      vld_p3_q <= vld_p2_q & wf_p2_q;
      if (vld_p2_q & wf_p2_q) begin
        sum_p3_q <= acc_p2_q;
        avg_p3_q <= round_avg(acc_p2_q);
      end
    end
  end

  assign out_valid = vld_p3_q;
  assign sum_o     = sum_p3_q;
  assign avg_o     = avg_p3_q;
  assign full      = (state_q == RUN);

endmodule
